// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiply and restoring divide
// on operand magnitudes, BITS_PER_CYCLE bits per iteration, sign fix-up on the last step.
module muldiv_unit #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1,
    parameter int TAG_W          = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             kill,
    input  logic [2:0]       funct3,
    input  logic [XLEN-1:0]  srcA,
    input  logic [XLEN-1:0]  srcB,
    input  logic [TAG_W-1:0] rd_in,
    output logic             stall,
    output logic             valid,
    output logic [XLEN-1:0]  result,
    output logic [TAG_W-1:0] rd_out
);
    localparam int N     = XLEN / BITS_PER_CYCLE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [XLEN-1:0]   hi_reg, lo_reg, b_reg;
    logic [2:0]        op_reg;
    logic              neg_a_reg, neg_b_reg;
    logic [TAG_W-1:0]  tag_reg;
    logic [XLEN-1:0]   result_reg;
    logic [TAG_W-1:0]  rd_out_reg;

    // Operand decode for the incoming request
    logic            is_div, a_signed, b_signed, neg_a, neg_b;
    logic            div_by_zero, div_overflow, special;
    logic [XLEN-1:0] mag_a, mag_b, special_result;

    assign is_div       = funct3[2];
    assign a_signed     = is_div ? !funct3[0] : (funct3[1:0] == 2'b01 || funct3[1:0] == 2'b10);
    assign b_signed     = is_div ? !funct3[0] : (funct3[1:0] == 2'b01);
    assign neg_a        = a_signed & srcA[XLEN-1];
    assign neg_b        = b_signed & srcB[XLEN-1];
    assign mag_a        = neg_a ? -srcA : srcA;
    assign mag_b        = neg_b ? -srcB : srcB;
    assign div_by_zero  = is_div && (srcB == '0);
    assign div_overflow = is_div && !funct3[0] && (srcA == MOST_NEG) && (srcB == '1);
    assign special      = div_by_zero || div_overflow;
    assign special_result = div_by_zero ? (funct3[1] ? srcA : '1)
                                        : (funct3[1] ? '0 : srcA);

    // Chain of single-bit steps; hi holds accumulator/remainder, lo holds multiplier/quotient
    logic [XLEN-1:0] hi_s [0:BITS_PER_CYCLE];
    logic [XLEN-1:0] lo_s [0:BITS_PER_CYCLE];

    assign hi_s[0] = hi_reg;
    assign lo_s[0] = lo_reg;

    generate
        for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_step
            logic [XLEN:0]   sum;
            logic [XLEN:0]   shifted;
            logic [XLEN-1:0] diff;
            logic            ge;

            assign sum     = {1'b0, hi_s[gi]} + (lo_s[gi][0] ? {1'b0, b_reg} : '0);
            assign shifted = {hi_s[gi], lo_s[gi][XLEN-1]};
            assign ge      = shifted >= {1'b0, b_reg};
            assign diff    = shifted[XLEN-1:0] - b_reg;

            assign hi_s[gi+1] = op_reg[2] ? (ge ? diff : shifted[XLEN-1:0]) : sum[XLEN:1];
            assign lo_s[gi+1] = op_reg[2] ? {lo_s[gi][XLEN-2:0], ge}
                                          : {sum[0], lo_s[gi][XLEN-1:1]};
        end
    endgenerate

    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, final_result;

    assign prod     = {hi_s[BITS_PER_CYCLE], lo_s[BITS_PER_CYCLE]};
    assign prod_fix = (neg_a_reg ^ neg_b_reg) ? -prod : prod;
    assign quo_fix  = (neg_a_reg ^ neg_b_reg) ? -lo_s[BITS_PER_CYCLE] : lo_s[BITS_PER_CYCLE];
    assign rem_fix  = neg_a_reg ? -hi_s[BITS_PER_CYCLE] : hi_s[BITS_PER_CYCLE];

    always_comb begin
        final_result = prod_fix[XLEN-1:0];
        case (op_reg)
            3'b000:                 final_result = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: final_result = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         final_result = quo_fix;
            default:                final_result = rem_fix;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            b_reg      <= '0;
            op_reg     <= '0;
            neg_a_reg  <= 1'b0;
            neg_b_reg  <= 1'b0;
            tag_reg    <= '0;
            result_reg <= '0;
            rd_out_reg <= '0;
        end else if (kill) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                CALC: begin
                    hi_reg  <= hi_s[BITS_PER_CYCLE];
                    lo_reg  <= lo_s[BITS_PER_CYCLE];
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == CNT_W'(N-1)) begin
                        result_reg <= final_result;
                        rd_out_reg <= tag_reg;
                        state_reg  <= DONE;
                    end
                end
                default: begin
                    if (start) begin
                        op_reg    <= funct3;
                        neg_a_reg <= neg_a;
                        neg_b_reg <= neg_b;
                        tag_reg   <= rd_in;
                        hi_reg    <= '0;
                        lo_reg    <= mag_a;
                        b_reg     <= mag_b;
                        cnt_reg   <= '0;
                        if (special) begin
                            result_reg <= special_result;
                            rd_out_reg <= rd_in;
                            state_reg  <= DONE;
                        end else begin
                            state_reg <= CALC;
                        end
                    end else begin
                        state_reg <= IDLE;
                    end
                end
            endcase
        end
    end

    assign stall  = (start && state_reg != CALC && !kill) || (state_reg == CALC);
    assign valid  = (state_reg == DONE) && !kill;
    assign result = result_reg;
    assign rd_out = rd_out_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: three configurations (32/1, 32/4, 64/4), directed vectors,
// expected result/tag/completion cycle queued at issue and checked by a valid-driven monitor.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  funct3;
    logic [63:0] src_a, src_b;
    logic [4:0]  rd_in;
    logic        start_w [3];
    logic        kill_w  [3];
    logic        stall_w [3];
    logic        valid_w [3];
    logic [4:0]  rd_w    [3];
    logic [63:0] res_w   [3];
    logic [31:0] res0, res1;
    logic [63:0] res2;

    always #5 clk = ~clk;

    assign res_w[0] = {32'b0, res0};
    assign res_w[1] = {32'b0, res1};
    assign res_w[2] = res2;

    muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(1), .TAG_W(5)) u_md0 (
        .clk(clk), .rst(rst), .start(start_w[0]), .kill(kill_w[0]), .funct3(funct3),
        .srcA(src_a[31:0]), .srcB(src_b[31:0]), .rd_in(rd_in), .stall(stall_w[0]),
        .valid(valid_w[0]), .result(res0), .rd_out(rd_w[0]));

    muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(4), .TAG_W(5)) u_md1 (
        .clk(clk), .rst(rst), .start(start_w[1]), .kill(kill_w[1]), .funct3(funct3),
        .srcA(src_a[31:0]), .srcB(src_b[31:0]), .rd_in(rd_in), .stall(stall_w[1]),
        .valid(valid_w[1]), .result(res1), .rd_out(rd_w[1]));

    muldiv_unit #(.XLEN(64), .BITS_PER_CYCLE(4), .TAG_W(5)) u_md2 (
        .clk(clk), .rst(rst), .start(start_w[2]), .kill(kill_w[2]), .funct3(funct3),
        .srcA(src_a), .srcB(src_b), .rd_in(rd_in), .stall(stall_w[2]),
        .valid(valid_w[2]), .result(res2), .rd_out(rd_w[2]));

    typedef struct {
        logic [63:0] r;
        logic [4:0]  t;
        int          c;
    } exp_t;

    exp_t q0[$], q1[$], q2[$];
    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int qsize(input int k);
        case (k)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic void push(input int k, input exp_t e);
        case (k)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endfunction

    function automatic exp_t pop(input int k);
        case (k)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    // Monitor: every valid pulse must match the oldest queued expectation, including its cycle
    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            if (valid_w[k]) begin
                tests++;
                if (qsize(k) == 0) begin
                    fails++;
                    $display("FAIL unexpected_valid dut%0d cyc=%0d result=%h rd=%0d",
                             k, cyc, res_w[k], rd_w[k]);
                end else begin
                    e = pop(k);
                    if (res_w[k] !== e.r || rd_w[k] !== e.t || cyc != e.c) begin
                        fails++;
                        $display("FAIL result dut%0d: got %h rd=%0d cyc=%0d, expected %h rd=%0d cyc=%0d",
                                 k, res_w[k], rd_w[k], cyc, e.r, e.t, e.c);
                    end else begin
                        $display("[TB] dut%0d result=%h rd=%0d cyc=%0d ok", k, res_w[k], rd_w[k], cyc);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input int k, input logic [2:0] f3, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] tag,
                         input logic [63:0] exp, input int lat, output int expc);
        exp_t e;
        funct3     = f3;
        src_a      = a;
        src_b      = b;
        rd_in      = tag;
        start_w[k] = 1'b1;
        expc       = cyc + lat;
        e.r = exp;
        e.t = tag;
        e.c = expc;
        push(k, e);
        #1;
        check("stall_start", {63'b0, stall_w[k]}, 64'd1);
    endtask

    task automatic finish_op(input int k, input int expc);
        int budget;
        step();
        start_w[k] = 1'b0;
        src_a      = '1;
        src_b      = '1;
        #1;
        budget = 300;
        while (qsize(k) != 0 && budget > 0) begin
            check("stall_busy", {63'b0, stall_w[k]}, {63'b0, (cyc < expc)});
            step();
            budget--;
        end
        if (qsize(k) != 0) begin
            tests++;
            fails++;
            $display("FAIL timeout dut%0d: %0d results outstanding, expected 0", k, qsize(k));
            while (qsize(k) != 0) void'(pop(k));
        end
    endtask

    task automatic run_op(input int k, input logic [2:0] f3, input logic [63:0] a,
                          input logic [63:0] b, input logic [4:0] tag,
                          input logic [63:0] exp, input int lat);
        int expc;
        issue(k, f3, a, b, tag, exp, lat, expc);
        finish_op(k, expc);
    endtask

    initial begin
        int expc;
        int budget;
        rst    = 1'b1;
        funct3 = 3'b000;
        src_a  = '0;
        src_b  = '0;
        rd_in  = '0;
        for (int k = 0; k < 3; k++) begin
            start_w[k] = 1'b0;
            kill_w[k]  = 1'b0;
        end
        repeat (3) step();
        rst = 1'b0;
        step();
        for (int k = 0; k < 3; k++) begin
            check("reset_result", res_w[k], 64'd0);
            check("reset_rd",     {59'b0, rd_w[k]}, 64'd0);
            check("reset_stall",  {63'b0, stall_w[k]}, 64'd0);
            check("reset_valid",  {63'b0, valid_w[k]}, 64'd0);
        end

        // XLEN=32, one bit per cycle: N=32, latency 33
        run_op(0, 3'b000, 64'h7,        64'hFFFFFFFD, 5'd3,  64'hFFFFFFEB, 33);
        run_op(0, 3'b011, 64'hFFFFFFFF, 64'hFFFFFFFF, 5'd4,  64'hFFFFFFFE, 33);
        run_op(0, 3'b001, 64'hFFFFFFFF, 64'hFFFFFFFF, 5'd5,  64'h00000000, 33);
        run_op(0, 3'b010, 64'hFFFFFFFF, 64'h2,        5'd6,  64'hFFFFFFFF, 33);
        run_op(0, 3'b001, 64'hFFFFFFF9, 64'h2,        5'd7,  64'hFFFFFFFF, 33);
        run_op(0, 3'b100, 64'hFFFFFFF9, 64'h2,        5'd8,  64'hFFFFFFFD, 33);
        run_op(0, 3'b110, 64'hFFFFFFF9, 64'h2,        5'd9,  64'hFFFFFFFF, 33);
        run_op(0, 3'b100, 64'h7,        64'hFFFFFFFE, 5'd10, 64'hFFFFFFFD, 33);
        run_op(0, 3'b110, 64'h7,        64'hFFFFFFFE, 5'd11, 64'h00000001, 33);
        run_op(0, 3'b101, 64'd100,      64'd7,        5'd12, 64'd14,       33);
        // Divide special cases complete in one cycle
        run_op(0, 3'b100, 64'd5,        64'd0,        5'd13, 64'hFFFFFFFF, 1);
        run_op(0, 3'b110, 64'd5,        64'd0,        5'd14, 64'd5,        1);
        run_op(0, 3'b101, 64'd9,        64'd0,        5'd15, 64'hFFFFFFFF, 1);
        run_op(0, 3'b100, 64'h80000000, 64'hFFFFFFFF, 5'd16, 64'h80000000, 1);
        run_op(0, 3'b110, 64'h80000000, 64'hFFFFFFFF, 5'd17, 64'h00000000, 1);
        run_op(0, 3'b111, 64'd100,      64'd7,        5'd18, 64'd2,        33);

        // Kill ten cycles into a DIV: no valid, stall drops, result keeps 2 / tag 18
        funct3     = 3'b100;
        src_a      = 64'hFFFFFFF9;
        src_b      = 64'h2;
        rd_in      = 5'd19;
        start_w[0] = 1'b1;
        step();
        start_w[0] = 1'b0;
        repeat (9) step();
        kill_w[0] = 1'b1;
        step();
        kill_w[0] = 1'b0;
        #1;
        check("kill_stall", {63'b0, stall_w[0]}, 64'd0);
        repeat (40) step();
        check("kill_result", res_w[0], 64'd2);
        check("kill_rd", {59'b0, rd_w[0]}, 64'd18);

        // XLEN=32, four bits per cycle: second op started in the DONE cycle of the first
        issue(1, 3'b000, 64'h7, 64'hFFFFFFFD, 5'd1, 64'hFFFFFFEB, 9, expc);
        step();
        start_w[1] = 1'b0;
        #1;
        budget = 50;
        while (!valid_w[1] && budget > 0) begin
            step();
            budget--;
        end
        check("b2b_first_valid_seen", {63'b0, valid_w[1]}, 64'd1);
        issue(1, 3'b101, 64'd100, 64'd7, 5'd2, 64'd14, 9, expc);
        finish_op(1, expc);

        // XLEN=64, four bits per cycle: N=16, latency 17
        run_op(2, 3'b101, 64'h0000010000000000, 64'd3, 5'd20, 64'd366503875925, 17);
        run_op(2, 3'b011, 64'h0000000100000000, 64'h0000000100000000, 5'd21, 64'd1, 17);
        run_op(2, 3'b000, 64'h0000000100000000, 64'h0000000100000000, 5'd22, 64'd0, 17);

        // Reset ten cycles into a DIV: no valid, stall drops, result/tag cleared
        funct3     = 3'b100;
        src_a      = 64'd100;
        src_b      = 64'd7;
        rd_in      = 5'd23;
        start_w[0] = 1'b1;
        step();
        start_w[0] = 1'b0;
        repeat (9) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("rst_stall", {63'b0, stall_w[0]}, 64'd0);
        repeat (40) step();
        check("rst_result", res_w[0], 64'd0);
        check("rst_rd", {59'b0, rd_w[0]}, 64'd0);

        step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
